// File: rtl/antifi_state_seq.sv
// antifi_state_seq: sequences one substitution pass over a 16-byte state
// held in an internal buffer. Bytes are sent to NLANE external Sbox lanes in
// B = 16/NLANE beats. Results come back PIPE cycles later and are written
// into the same byte positions. There is no handshake: a PIPE-deep
// valid/beat-index delay line says which result arrives on which cycle.
//
// Ports
//   clk_i, arstn_i     clock; asynchronous active-low reset (deassertion
//                      is synchronised internally)
//   start_i, abort_i   load state_i and run a pass; cancel the pass (wins)
//   state_i            16 x L-bit input state, byte i at [i*L +: L]
//   sb_x_o, sb_vld_o   beat presented to the Sbox lanes (zero when idle)
//   sb_q_i             Sbox results, PIPE cycles after the matching beat
//   state_o            internal state buffer
//   busy_o, done_o     pass in progress; one-cycle completion pulse

// One Sbox lane: selects byte beat*NLANE+LANE from the buffer. The output is
// forced to zero outside valid beats so the lane wires do not toggle with
// the data.
module antifi_state_seq_lane #(
  parameter int L     = 16,
  parameter int NLANE = 4,
  parameter int BW    = 2,
  parameter int LANE  = 0
) (
  input  logic [15:0][L-1:0] buf_i,
  input  logic [BW-1:0]      beat_i,
  input  logic               vld_i,
  output logic [L-1:0]       x_o
);
  logic [3:0] sel;

  always_comb begin
    sel = 4'(int'(beat_i) * NLANE + LANE);
    x_o = vld_i ? buf_i[sel] : '0;
  end
endmodule

module antifi_state_seq #(
  parameter int L     = 16,
  parameter int NLANE = 4,
  parameter int PIPE  = 2
) (
  input  logic                 clk_i,
  input  logic                 arstn_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [16*L-1:0]      state_i,
  output logic [NLANE*L-1:0]   sb_x_o,
  output logic                 sb_vld_o,
  input  logic [NLANE*L-1:0]   sb_q_i,
  output logic [16*L-1:0]      state_o,
  output logic                 busy_o,
  output logic                 done_o
);
  localparam int B  = 16 / NLANE;
  localparam int BW = (B > 1) ? $clog2(B) : 1;

  if ((NLANE < 1) || ((16 % NLANE) != 0) || (PIPE < 0) || (PIPE > 7)) begin : g_bad_param
    $error("antifi_state_seq: NLANE must divide 16 and PIPE must be 0..7");
  end

  // Reset: asserts asynchronously, releases on the second clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} st_e;

  st_e                 st_q, st_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [15:0][L-1:0]  buf_q, buf_d;

  // Stage 0 is the beat on the Sbox inputs this cycle; stage PIPE is the
  // beat whose result is on sb_q_i this cycle.
  logic [PIPE:0]         vld_pipe;
  logic [PIPE:0][BW-1:0] idx_pipe;
  logic                  cap;

  assign vld_pipe[0] = (st_q == ISSUE);
  assign idx_pipe[0] = beat_q;
  assign sb_vld_o    = vld_pipe[0];

  if (PIPE > 0) begin : g_dl
    logic [PIPE-1:0]         dl_vld_q, dl_vld_d;
    logic [PIPE-1:0][BW-1:0] dl_idx_q, dl_idx_d;

    always_comb begin
      dl_vld_d    = '0;
      dl_idx_d    = '0;
      dl_vld_d[0] = vld_pipe[0];
      dl_idx_d[0] = idx_pipe[0];
      for (int i = 1; i < PIPE; i++) begin
        dl_vld_d[i] = dl_vld_q[i-1];
        dl_idx_d[i] = dl_idx_q[i-1];
      end
      // Abort flushes everything still in flight.
      if (abort_i) dl_vld_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
        dl_vld_q <= '0;
        dl_idx_q <= '0;
      end else begin
        dl_vld_q <= dl_vld_d;
        dl_idx_q <= dl_idx_d;
      end
    end

    assign vld_pipe[PIPE:1] = dl_vld_q;
    assign idx_pipe[PIPE:1] = dl_idx_q;
  end

  // A result arriving on an abort edge is dropped.
  assign cap = vld_pipe[PIPE] && !abort_i;

  always_comb begin
    st_d   = st_q;
    beat_d = beat_q;
    buf_d  = buf_q;

    if (cap) begin
      for (int j = 0; j < NLANE; j++)
        buf_d[4'(int'(idx_pipe[PIPE]) * NLANE + j)] = sb_q_i[j*L +: L];
    end

    unique case (st_q)
      IDLE: begin
        if (start_i) begin
          buf_d  = state_i;
          beat_d = '0;
          st_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (beat_q == BW'(B-1)) begin
          beat_d = '0;
          st_d   = (PIPE > 0) ? DRAIN : DONE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      DRAIN: begin
        if (vld_pipe[PIPE] && (idx_pipe[PIPE] == BW'(B-1))) st_d = DONE;
      end
      DONE:    st_d = IDLE;
      default: st_d = IDLE;
    endcase

    // Abort overrides everything, including a simultaneous start in IDLE.
    if (abort_i) begin
      st_d   = IDLE;
      beat_d = '0;
      if (st_q == IDLE) buf_d = buf_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      beat_q <= '0;
      buf_q  <= '0;
    end else begin
      st_q   <= st_d;
      beat_q <= beat_d;
      buf_q  <= buf_d;
    end
  end

  for (genvar g = 0; g < NLANE; g++) begin : g_lane
    antifi_state_seq_lane #(
      .L(L), .NLANE(NLANE), .BW(BW), .LANE(g)
    ) u_lane (
      .buf_i  (buf_q),
      .beat_i (beat_q),
      .vld_i  (sb_vld_o),
      .x_o    (sb_x_o[g*L +: L])
    );
  end

  assign state_o = buf_q;
  assign busy_o  = (st_q != IDLE);
  assign done_o  = (st_q == DONE) && !abort_i;
endmodule

// File: tb/tb_antifi_state_seq.sv
module tb_antifi_state_seq;
  logic clk = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;
  int vc, dc, d1, d2, bc;
  logic [255:0] e, e2;

  // u0: defaults (NLANE=4, PIPE=2)
  logic start0 = 0, abort0 = 0, vld0, busy0, done0;
  logic [255:0] st0 = '0, so0, f0;
  logic [63:0]  x0, q0, p0a, p0b;
  // u1: NLANE=16, PIPE=0
  logic start1 = 0, abort1 = 0, vld1, busy1, done1;
  logic [255:0] st1 = '0, so1, x1, q1;
  // u2: NLANE=1, PIPE=3
  logic start2 = 0, abort2 = 0, vld2, busy2, done2;
  logic [255:0] st2 = '0, so2, f2;
  logic [15:0]  x2, q2, p2a, p2b, p2c;

  antifi_state_seq u0 (
    .clk_i(clk), .arstn_i(arstn), .start_i(start0), .abort_i(abort0),
    .state_i(st0), .sb_x_o(x0), .sb_vld_o(vld0), .sb_q_i(q0),
    .state_o(so0), .busy_o(busy0), .done_o(done0));

  antifi_state_seq #(.L(16), .NLANE(16), .PIPE(0)) u1 (
    .clk_i(clk), .arstn_i(arstn), .start_i(start1), .abort_i(abort1),
    .state_i(st1), .sb_x_o(x1), .sb_vld_o(vld1), .sb_q_i(q1),
    .state_o(so1), .busy_o(busy1), .done_o(done1));

  antifi_state_seq #(.L(16), .NLANE(1), .PIPE(3)) u2 (
    .clk_i(clk), .arstn_i(arstn), .start_i(start2), .abort_i(abort2),
    .state_i(st2), .sb_x_o(x2), .sb_vld_o(vld2), .sb_q_i(q2),
    .state_o(so2), .busy_o(busy2), .done_o(done2));

  // Sbox model: +0x100 per 16-bit lane
  function automatic logic [255:0] addk(input logic [255:0] v, input int n);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i*16 +: 16] = v[i*16 +: 16] + 16'h100;
    return r;
  endfunction

  // 16 bytes, byte i = base + i + add
  function automatic logic [255:0] mk(input int base, input int add);
    logic [255:0] r;
    for (int i = 0; i < 16; i++) r[i*16 +: 16] = 16'(base + i + add);
    return r;
  endfunction

  assign f0 = addk({192'b0, x0}, 4);
  always @(posedge clk) begin
    p0a <= f0[63:0];
    p0b <= p0a;
  end
  assign q0 = p0b;

  assign q1 = addk(x1, 16);

  assign f2 = addk({240'b0, x2}, 1);
  always @(posedge clk) begin
    p2a <= f2[15:0];
    p2b <= p2a;
    p2c <= p2b;
  end
  assign q2 = p2c;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    tick(); tick();
    chk("rst_out", {busy0, done0, vld0, x0}, 0);
    chk("rst_state", so0, 0);
    arstn = 1'b1;
    repeat (4) tick();

    // A: basic pass, default params
    st0 = mk(0, 0); start0 = 1; tick(); start0 = 0;
    vc = 0; dc = 0; d1 = 0;
    e = mk(0, 0);
    for (int m = 1; m <= 10; m++) begin
      if (vld0) vc++;
      if (done0) begin dc++; d1 = m; end
      if (m == 1) chk("a_beat0", x0, e[63:0]);
      if (m == 2) chk("a_beat1", x0, e[127:64]);
      if (m == 6) chk("a_idle_x", {vld0, x0}, 0);
      tick();
    end
    chk("a_vcnt", vc, 4);
    chk("a_dcnt", dc, 1);
    chk("a_dcyc", d1, 7);
    chk("a_state", so0, mk(0, 256));
    chk("a_busy", busy0, 0);

    // B: start during pass ignored, start after done accepted
    st0 = mk(32, 0); start0 = 1; tick(); start0 = 0;
    dc = 0; d1 = 0; d2 = 0;
    for (int m = 1; m <= 17; m++) begin
      if (m == 3) begin st0 = mk(64, 0); start0 = 1; end
      if (m == 4) start0 = 0;
      if (m == 8) begin
        chk("b_first", so0, mk(32, 256));
        st0 = mk(96, 0); start0 = 1;
      end
      if (m == 9) start0 = 0;
      if (done0) begin
        dc++;
        if (dc == 1) d1 = m; else d2 = m;
      end
      tick();
    end
    chk("b_dcnt", dc, 2);
    chk("b_d1", d1, 7);
    chk("b_d2", d2, 15);
    chk("b_state", so0, mk(96, 256));

    // C: abort at t0+4
    st0 = mk(128, 0); start0 = 1; tick(); start0 = 0;
    dc = 0;
    for (int m = 1; m <= 9; m++) begin
      if (m == 4) abort0 = 1;
      if (m == 5) begin abort0 = 0; chk("c_busy", busy0, 0); end
      if (done0) dc++;
      tick();
    end
    e = mk(128, 0); e2 = mk(128, 256); e[63:0] = e2[63:0];
    chk("c_done", dc, 0);
    chk("c_state", so0, e);
    // abort beats start in IDLE
    st0 = mk(200, 0); start0 = 1; abort0 = 1; tick(); start0 = 0; abort0 = 0;
    chk("c_prio_busy", busy0, 0);
    chk("c_prio_state", so0, e);

    // D: NLANE=16, PIPE=0
    st1 = mk(160, 0); start1 = 1; tick(); start1 = 0;
    bc = 0; vc = 0; dc = 0; d1 = 0;
    for (int m = 1; m <= 5; m++) begin
      if (busy1) bc++;
      if (vld1) vc++;
      if (done1) begin dc++; d1 = m; end
      if (m == 1) chk("d_beat", x1, mk(160, 0));
      tick();
    end
    chk("d_busy", bc, 2);
    chk("d_vld", vc, 1);
    chk("d_dcnt", dc, 1);
    chk("d_dcyc", d1, 2);
    chk("d_state", so1, mk(160, 256));

    // E: NLANE=1, PIPE=3
    st2 = mk(192, 0); start2 = 1; tick(); start2 = 0;
    vc = 0; dc = 0; d1 = 0;
    for (int m = 1; m <= 24; m++) begin
      if (vld2) begin
        chk("e_lane", x2, 16'(192 + vc));
        vc++;
      end
      if (done2) begin dc++; d1 = m; end
      tick();
    end
    chk("e_vld", vc, 16);
    chk("e_dcnt", dc, 1);
    chk("e_dcyc", d1, 20);
    chk("e_state", so2, mk(192, 256));

    // F: reset mid-DRAIN
    st0 = mk(224, 0); start0 = 1; tick(); start0 = 0;
    repeat (4) tick();
    chk("f_busy_pre", busy0, 1);
    arstn = 1'b0;
    #2;
    chk("f_rst_out", {busy0, done0, vld0, x0}, 0);
    chk("f_rst_state", so0, 0);
    tick(); tick();
    arstn = 1'b1;
    dc = 0;
    for (int m = 1; m <= 12; m++) begin
      if (done0) dc++;
      tick();
    end
    chk("f_nodone", dc, 0);
    st0 = mk(16, 0); start0 = 1; tick(); start0 = 0;
    dc = 0; d1 = 0;
    for (int m = 1; m <= 10; m++) begin
      if (done0) begin dc++; d1 = m; end
      tick();
    end
    chk("f_dcnt", dc, 1);
    chk("f_dcyc", d1, 7);
    chk("f_state", so0, mk(16, 256));

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
